// File: rtl/envelope_follower.sv
// Per-band envelope follower: rectify + shift-coefficient one-pole smoother,
// one shared datapath walked across bands, array published atomically.
package envelope_pkg;
    localparam int N_FILTERS = 4;
endpackage

module envelope_follower
    import envelope_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                valid_in,
    input  logic [4:0]          attack_shift,
    input  logic [4:0]          release_shift,
    input  logic signed [31:0]  filtered_channels [N_FILTERS],
    output logic signed [31:0]  envelope_channels [N_FILTERS],
    output logic                valid_out,
    output logic                busy
);
    localparam int IW = $clog2(N_FILTERS);
    localparam logic signed [31:0] MAX_V = 32'sh7fff_ffff;
    localparam logic signed [31:0] MIN_V = 32'sh8000_0000;

    typedef enum logic [1:0] {IDLE, RECTIFY, UPDATE} state_t;

    state_t             state;
    state_t             state_next;
    logic [IW-1:0]      index;
    logic signed [31:0] snap [N_FILTERS];
    logic signed [31:0] env [N_FILTERS];
    logic signed [31:0] rect;
    logic [4:0]         shift;

    logic signed [31:0] sample;
    logic signed [31:0] env_cur;
    logic signed [31:0] rect_cand;
    logic signed [31:0] env_new;
    logic signed [32:0] diff;
    logic signed [32:0] step;
    logic               last;

    always_comb begin
        sample  = snap[index];
        env_cur = env[index];
        // |-2^31| does not fit, clamp it to the largest positive value
        if (sample == MIN_V)
            rect_cand = MAX_V;
        else if (sample < 0)
            rect_cand = -sample;
        else
            rect_cand = sample;
        diff    = {rect[31], rect} - {env_cur[31], env_cur};
        step    = diff >>> shift;
        env_new = env_cur + step[31:0];
        last    = (index == IW'(N_FILTERS - 1));
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (valid_in) state_next = RECTIFY;
            RECTIFY: state_next = UPDATE;
            UPDATE:  state_next = last ? IDLE : RECTIFY;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            index     <= '0;
            rect      <= '0;
            shift     <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < N_FILTERS; i++) begin
                snap[i]              <= '0;
                env[i]               <= '0;
                envelope_channels[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in) begin
                        for (int i = 0; i < N_FILTERS; i++)
                            snap[i] <= filtered_channels[i];
                        index <= '0;
                        busy  <= 1'b1;
                    end
                end
                RECTIFY: begin
                    rect  <= rect_cand;
                    shift <= (rect_cand > env_cur) ? attack_shift : release_shift;
                end
                UPDATE: begin
                    env[index] <= env_new;
                    if (last) begin
                        for (int i = 0; i < N_FILTERS; i++)
                            envelope_channels[i] <= (IW'(i) == index) ? env_new : env[i];
                        valid_out <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_envelope_follower.sv
// Self-checking bench for envelope_follower: directed table, handshake,
// reset and randomized frames against an arithmetic reference model.
module tb_envelope_follower;
    import envelope_pkg::*;

    localparam longint MAXV = 64'sd2147483647;
    localparam int LAT = 2 * N_FILTERS + 1;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               valid_in = 1'b0;
    logic [4:0]         attack_shift = '0;
    logic [4:0]         release_shift = '0;
    logic signed [31:0] filtered_channels [N_FILTERS];
    logic signed [31:0] envelope_channels [N_FILTERS];
    logic               valid_out;
    logic               busy;

    envelope_follower dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .valid_in(valid_in),
        .attack_shift(attack_shift),
        .release_shift(release_shift),
        .filtered_channels(filtered_channels),
        .envelope_channels(envelope_channels),
        .valid_out(valid_out),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    int passed = 0;
    int total = 0;
    longint model_env [N_FILTERS];
    logic signed [31:0] cur_ch [N_FILTERS];
    logic [4:0] cur_atk;
    logic [4:0] cur_rel;

    typedef struct {
        bit     rst;
        int     ch0, ch1, ch2;
        int     atk, rel;
        longint e0, e1, e2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: env += floor((|x| sat - env) / 2^shift)
    function automatic void model_step(input int c, input longint s,
                                       input int atk, input int rel);
        longint r, d;
        int sh;
        r = (s < 0) ? -s : s;
        if (r > MAXV) r = MAXV;
        sh = (r > model_env[c]) ? atk : rel;
        d = r - model_env[c];
        model_env[c] = model_env[c] + (d >>> sh);
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        for (int c = 0; c < N_FILTERS; c++) model_env[c] = 0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic run_frame(input bit mid, input logic [4:0] atk2,
                             input logic [4:0] rel2, input bit glitch);
        longint prev [N_FILTERS];
        for (int c = 0; c < N_FILTERS; c++) prev[c] = envelope_channels[c];
        filtered_channels = cur_ch;
        attack_shift = cur_atk;
        release_shift = cur_rel;
        valid_in = 1'b1;
        for (int c = 0; c < N_FILTERS; c++)
            model_step(c, cur_ch[c], (mid && c > 0) ? atk2 : cur_atk,
                       (mid && c > 0) ? rel2 : cur_rel);
        for (int m = 1; m <= LAT + 1; m++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
            if (glitch && (m == 1 || m == 5)) begin
                valid_in = 1'b1;
                for (int c = 0; c < N_FILTERS; c++)
                    filtered_channels[c] = $urandom();
            end
            if (mid && m == 3) begin
                attack_shift = atk2;
                release_shift = rel2;
            end
            check("valid_out_timing", valid_out, (m == LAT) ? 1 : 0);
            check("busy", busy, (m < LAT) ? 1 : 0);
            if (m == LAT - 1)
                for (int c = 0; c < N_FILTERS; c++)
                    check("env_stable", envelope_channels[c], prev[c]);
            if (m == LAT)
                for (int c = 0; c < N_FILTERS; c++)
                    check("env_model", envelope_channels[c], model_env[c]);
        end
    endtask

    initial begin
        for (int c = 0; c < N_FILTERS; c++) begin
            filtered_channels[c] = '0;
            cur_ch[c] = '0;
        end
        vecs[0] = '{1, 1000, -500, int'(32'h8000_0000), 0, 0, 1000, 500, MAXV};
        vecs[1] = '{1, 1024, 0, 0, 2, 0, 256, 0, 0};
        vecs[2] = '{0, 1024, 0, 0, 2, 0, 448, 0, 0};
        vecs[3] = '{0, 1024, 0, 0, 2, 0, 592, 0, 0};
        vecs[4] = '{1, 1024, 0, 0, 0, 0, 1024, 0, 0};
        vecs[5] = '{0, 0, 0, 0, 0, 3, 896, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 3, 784, 0, 0};
        vecs[7] = '{1, -1024, 0, 0, 0, 0, 1024, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 3, 896, 0, 0};
        vecs[9] = '{0, 0, 0, 0, 0, 3, 784, 0, 0};

        do_reset();
        for (int c = 0; c < N_FILTERS; c++)
            check("reset_env", envelope_channels[c], 0);
        check("reset_valid_out", valid_out, 0);
        check("reset_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            check("idle_no_valid_out", valid_out, 0);
        end

        for (int v = 0; v < 10; v++) begin
            longint ex [N_FILTERS];
            if (vecs[v].rst) do_reset();
            for (int c = 0; c < N_FILTERS; c++) begin
                cur_ch[c] = '0;
                ex[c] = 0;
            end
            cur_ch[0] = vecs[v].ch0;
            cur_ch[1] = vecs[v].ch1;
            cur_ch[2] = vecs[v].ch2;
            ex[0] = vecs[v].e0;
            ex[1] = vecs[v].e1;
            ex[2] = vecs[v].e2;
            cur_atk = 5'(vecs[v].atk);
            cur_rel = 5'(vecs[v].rel);
            run_frame(0, 0, 0, 0);
            for (int c = 0; c < N_FILTERS; c++)
                check($sformatf("table%0d_ch%0d", v, c), envelope_channels[c], ex[c]);
        end

        // valid_in pulses while busy are dropped, snapshot is immune
        for (int c = 0; c < N_FILTERS; c++) cur_ch[c] = 32'(c * 7000 - 9000);
        cur_atk = 1;
        cur_rel = 2;
        run_frame(0, 0, 0, 1);
        @(negedge clk_in);
        check("glitch_no_extra_frame", busy, 0);

        // valid_in held high: one frame every LAT cycles
        begin
            int pulses = 0;
            for (int c = 0; c < N_FILTERS; c++) cur_ch[c] = 32'(50000 - c * 30000);
            filtered_channels = cur_ch;
            attack_shift = 1;
            release_shift = 1;
            valid_in = 1'b1;
            for (int f = 0; f < 3; f++)
                for (int c = 0; c < N_FILTERS; c++) model_step(c, cur_ch[c], 1, 1);
            for (int m = 1; m <= 3 * LAT + 2; m++) begin
                @(negedge clk_in);
                if (valid_out) begin
                    pulses++;
                    check("b2b_position", m, pulses * LAT);
                    if (pulses == 3) valid_in = 1'b0;
                end
            end
            check("b2b_pulses", pulses, 3);
            check("b2b_busy_end", busy, 0);
            for (int c = 0; c < N_FILTERS; c++)
                check("b2b_env", envelope_channels[c], model_env[c]);
        end

        // reset in the middle of a frame
        for (int c = 0; c < N_FILTERS; c++) cur_ch[c] = 32'd5000;
        filtered_channels = cur_ch;
        valid_in = 1'b1;
        for (int m = 1; m <= LAT + 3; m++) begin
            @(negedge clk_in);
            valid_in = 1'b0;
            if (m == 3) rst_in = 1'b1;
            if (m == 4) rst_in = 1'b0;
            check("midreset_no_valid_out", valid_out, 0);
        end
        check("midreset_busy", busy, 0);
        for (int c = 0; c < N_FILTERS; c++) begin
            check("midreset_env", envelope_channels[c], 0);
            model_env[c] = 0;
            cur_ch[c] = '0;
        end
        cur_ch[0] = 1024;
        cur_atk = 0;
        cur_rel = 0;
        run_frame(0, 0, 0, 0);
        check("after_reset_ch0", envelope_channels[0], 1024);

        // randomized frames, some with shifts changed mid-frame
        for (int f = 0; f < 24; f++) begin
            for (int c = 0; c < N_FILTERS; c++) begin
                if ($urandom_range(0, 7) == 0) cur_ch[c] = 32'sh8000_0000;
                else if ($urandom_range(0, 3) == 0) cur_ch[c] = 32'($urandom_range(0, 4000)) - 32'd2000;
                else cur_ch[c] = $urandom();
            end
            cur_atk = 5'($urandom_range(0, 31));
            cur_rel = 5'($urandom_range(0, 31));
            run_frame(f[0], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
